// File: rtl/inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// inst_fetch_ctrl
//
// Fetch sequencer for the single-issue RISC-V core. Owns the fetch PC, presents
// it to the instruction memory, and captures the returned word into an IF/ID
// register guarded by a valid/stall handshake. Applies branch redirects,
// stops after the last program instruction, and faults on illegal addresses.
//
// Ports:
//   clk            in   1   rising-edge clock
//   reset          in   1   asynchronous active-low reset
//   start          in   1   leaves IDLE
//   stall          in   1   downstream not ready, holds a valid IF/ID entry
//   redirect       in   1   branch/jump taken
//   redirect_pc    in  64   redirect target
//   Inst_Address   out 64   current fetch PC, to instruction memory
//   Instruction    in  32   combinational read data from instruction memory
//   if_instruction out 32   IF/ID instruction
//   if_pc          out 64   IF/ID PC
//   if_valid       out  1   IF/ID entry valid
//   fetch_count    out 32   instructions delivered (wraps)
//   halted         out  1   last instruction delivered (sticky)
//   fault          out  1   illegal fetch address seen (sticky)
// -----------------------------------------------------------------------------
module inst_fetch_ctrl #(
    parameter logic [63:0] RESET_PC  = 64'd0,
    parameter int unsigned MEM_BYTES = 80,
    parameter logic [63:0] END_PC    = 64'd76
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic [63:0] Inst_Address,
    input  logic [31:0] Instruction,
    output logic [31:0] if_instruction,
    output logic [63:0] if_pc,
    output logic        if_valid,
    output logic [31:0] fetch_count,
    output logic        halted,
    output logic        fault
);

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t      state_q,  state_d;
    logic [63:0] pc_q,     pc_d;
    logic [31:0] inst_q,   inst_d;
    logic [63:0] ipc_q,    ipc_d;
    logic        valid_q,  valid_d;
    logic [31:0] count_q,  count_d;
    logic        halted_q, halted_d;
    logic        fault_q,  fault_d;
    logic        legal_s;

    // A fetch is legal when word aligned and the whole word lies inside memory.
    // The sum is formed in 65 bits so a PC near 2^64 cannot wrap into range.
    function automatic logic fetch_legal(input logic [63:0] pc);
        logic [64:0] end_addr;
        end_addr    = {1'b0, pc} + 65'd4;
        fetch_legal = (pc[1:0] == 2'b00) && (end_addr <= 65'(MEM_BYTES));
    endfunction

    assign legal_s        = fetch_legal(pc_q);
    assign Inst_Address   = pc_q;
    assign if_instruction = inst_q;
    assign if_pc          = ipc_q;
    assign if_valid       = valid_q;
    assign fetch_count    = count_q;
    assign halted         = halted_q;
    assign fault          = fault_q;

    // Next-state computation for the FSM and the IF/ID register.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        ipc_d    = ipc_q;
        valid_d  = valid_q;
        count_d  = count_q;
        halted_d = halted_q;
        fault_d  = fault_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                // Redirect wins over both stall and capture; the target's
                // legality is only judged when it is fetched next cycle.
                if (redirect) begin
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                end else if (valid_q && stall) begin
                    pc_d    = pc_q;
                    valid_d = valid_q;
                end else if (legal_s) begin
                    inst_d  = Instruction;
                    ipc_d   = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 64'd4;
                    count_d = count_q + 32'd1;
                    if (pc_q == END_PC) begin
                        state_d  = ST_DONE;
                        halted_d = 1'b1;
                    end else begin
                        state_d  = ST_FETCH;
                    end
                end else begin
                    valid_d = 1'b0;
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                end
            end
            ST_DONE: begin
                // The final instruction stays offered until it is consumed.
                if (!stall) begin
                    valid_d = 1'b0;
                end else begin
                    valid_d = valid_q;
                end
            end
            ST_FAULT: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            inst_q   <= NOP;
            ipc_q    <= 64'd0;
            valid_q  <= 1'b0;
            count_q  <= 32'd0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            ipc_q    <= ipc_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
module tb_inst_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stall;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic [63:0] Inst_Address;
    logic [31:0] Instruction;
    logic [31:0] if_instruction;
    logic [63:0] if_pc;
    logic        if_valid;
    logic [31:0] fetch_count;
    logic        halted;
    logic        fault;

    int n_tests;
    int n_fail;

    logic [31:0] mem [0:19];

    inst_fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .Inst_Address   (Inst_Address),
        .Instruction    (Instruction),
        .if_instruction (if_instruction),
        .if_pc          (if_pc),
        .if_valid       (if_valid),
        .fetch_count    (fetch_count),
        .halted         (halted),
        .fault          (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory
    always_comb begin
        if (Inst_Address < 64'd80) Instruction = mem[Inst_Address[6:2]];
        else                       Instruction = 32'hDEADBEEF;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0; start = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 64'd0;
        #2;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        step();
        reset = 1'b0;
        #1;
        n_tests++; if (Inst_Address !== 64'd0) begin n_fail++; $display("FAIL reset_addr: got %0h expected 0", Inst_Address); end
        n_tests++; if (if_instruction !== 32'h00000013) begin n_fail++; $display("FAIL reset_inst: got %h expected 00000013", if_instruction); end
        n_tests++; if (if_valid !== 1'b0 || if_pc !== 64'd0) begin n_fail++; $display("FAIL reset_ifid: valid %b pc %0h expected 0 0", if_valid, if_pc); end
        n_tests++; if (fetch_count !== 32'd0 || halted !== 1'b0 || fault !== 1'b0) begin n_fail++; $display("FAIL reset_status: cnt %0d halted %b fault %b expected 0 0 0", fetch_count, halted, fault); end
        reset = 1'b1;
    endtask

    task automatic test_fetch_stall_redirect();
        apply_reset();
        start = 1'b1; step(); start = 1'b0;
        n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL idle_no_capture: valid %b expected 0", if_valid); end
        step();
        n_tests++; if (if_pc !== 64'd0 || if_instruction !== 32'h00800593 || if_valid !== 1'b1) begin n_fail++; $display("FAIL edge1: pc %0h inst %h valid %b expected 0 00800593 1", if_pc, if_instruction, if_valid); end
        step();
        n_tests++; if (if_pc !== 64'd4 || if_instruction !== 32'h04b68463) begin n_fail++; $display("FAIL edge2: pc %0h inst %h expected 4 04b68463", if_pc, if_instruction); end
        n_tests++; if (Inst_Address !== 64'd8 || fetch_count !== 32'd2) begin n_fail++; $display("FAIL edge2_addr: addr %0h cnt %0d expected 8 2", Inst_Address, fetch_count); end
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++; if (if_pc !== 64'd8 || if_valid !== 1'b1 || if_instruction !== mem[2] || Inst_Address !== 64'd12 || fetch_count !== 32'd3) begin
                n_fail++; $display("FAIL stall_hold: pc %0h valid %b inst %h addr %0h cnt %0d expected 8 1 %h 12 3", if_pc, if_valid, if_instruction, Inst_Address, fetch_count, mem[2]);
            end
        end
        stall = 1'b0;
        step();
        n_tests++; if (if_pc !== 64'd12 || if_instruction !== 32'h01400ab3) begin n_fail++; $display("FAIL stall_release: pc %0h inst %h expected c 01400ab3", if_pc, if_instruction); end
        redirect = 1'b1; redirect_pc = 64'd64; stall = 1'b1;
        step();
        redirect = 1'b0; stall = 1'b0;
        n_tests++; if (if_valid !== 1'b0 || Inst_Address !== 64'd64) begin n_fail++; $display("FAIL redirect_flush: valid %b addr %0h expected 0 40", if_valid, Inst_Address); end
        step();
        n_tests++; if (if_pc !== 64'd64 || if_instruction !== 32'h008a0a13 || if_valid !== 1'b1) begin n_fail++; $display("FAIL redirect_target: pc %0h inst %h valid %b expected 40 008a0a13 1", if_pc, if_instruction, if_valid); end
    endtask

    task automatic test_straight_line();
        apply_reset();
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 20; i++) step();
        n_tests++; if (if_pc !== 64'd76 || if_instruction !== 32'h00000013 || halted !== 1'b1 || fetch_count !== 32'd20) begin
            n_fail++; $display("FAIL end_of_program: pc %0h inst %h halted %b cnt %0d expected 4c 00000013 1 20", if_pc, if_instruction, halted, fetch_count);
        end
        redirect = 1'b1; redirect_pc = 64'd0; start = 1'b1;
        step();
        redirect = 1'b0; start = 1'b0;
        n_tests++; if (if_valid !== 1'b0 || Inst_Address !== 64'd80 || fault !== 1'b0 || fetch_count !== 32'd20) begin
            n_fail++; $display("FAIL done_hold: valid %b addr %0h fault %b cnt %0d expected 0 50 0 20", if_valid, Inst_Address, fault, fetch_count);
        end
    endtask

    task automatic test_redirect_targets();
        apply_reset();
        start = 1'b1; step(); start = 1'b0;
        step();
        redirect = 1'b1; redirect_pc = 64'h42; step(); redirect = 1'b0;
        step();
        n_tests++; if (fault !== 1'b1 || if_valid !== 1'b0 || Inst_Address !== 64'h42) begin n_fail++; $display("FAIL misaligned_target: fault %b valid %b addr %0h expected 1 0 42", fault, if_valid, Inst_Address); end
        start = 1'b1; step(); start = 1'b0;
        n_tests++; if (fault !== 1'b1 || if_valid !== 1'b0 || Inst_Address !== 64'h42) begin n_fail++; $display("FAIL fault_sticky: fault %b valid %b addr %0h expected 1 0 42", fault, if_valid, Inst_Address); end
        apply_reset();
        start = 1'b1; step(); start = 1'b0;
        redirect = 1'b1; redirect_pc = 64'd80; step(); redirect = 1'b0;
        step();
        n_tests++; if (fault !== 1'b1 || if_valid !== 1'b0 || Inst_Address !== 64'd80) begin n_fail++; $display("FAIL out_of_range_target: fault %b valid %b addr %0h expected 1 0 50", fault, if_valid, Inst_Address); end
        apply_reset();
        start = 1'b1; step(); start = 1'b0;
        redirect = 1'b1; redirect_pc = 64'd76; step(); redirect = 1'b0;
        step();
        n_tests++; if (fault !== 1'b0 || if_valid !== 1'b1 || if_pc !== 64'd76 || halted !== 1'b1) begin n_fail++; $display("FAIL last_word_target: fault %b valid %b pc %0h halted %b expected 0 1 4c 1", fault, if_valid, if_pc, halted); end
    endtask

    task automatic test_reset_midrun();
        apply_reset();
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        #2;
        reset = 1'b0;
        #1;
        n_tests++; if (Inst_Address !== 64'd0 || if_valid !== 1'b0 || if_pc !== 64'd0 || if_instruction !== 32'h00000013 || fetch_count !== 32'd0) begin
            n_fail++; $display("FAIL async_reset: addr %0h valid %b pc %0h inst %h cnt %0d expected 0 0 0 00000013 0", Inst_Address, if_valid, if_pc, if_instruction, fetch_count);
        end
        reset = 1'b1;
        step();
        n_tests++; if (if_valid !== 1'b0 || Inst_Address !== 64'd0) begin n_fail++; $display("FAIL needs_start: valid %b addr %0h expected 0 0", if_valid, Inst_Address); end
        start = 1'b1; step(); start = 1'b0;
        step();
        n_tests++; if (if_pc !== 64'd0 || if_instruction !== 32'h00800593 || if_valid !== 1'b1) begin n_fail++; $display("FAIL refetch: pc %0h inst %h valid %b expected 0 00800593 1", if_pc, if_instruction, if_valid); end
    endtask

    // Randomized run against a behavioural model of the fetch rules
    task automatic test_random();
        bit          m_started, m_halt, m_fault, m_val;
        logic [63:0] m_pc, m_ipc;
        logic [31:0] m_ins, m_cnt;
        int          idle_end;
        logic [63:0] targets [0:5];
        targets[0] = 64'd0;  targets[1] = 64'd40; targets[2] = 64'd76;
        targets[3] = 64'd80; targets[4] = 64'h42; targets[5] = 64'd16;
        apply_reset();
        m_started = 0; m_halt = 0; m_fault = 0; m_val = 0;
        m_pc = 64'd0; m_ipc = 64'd0; m_ins = 32'h00000013; m_cnt = 32'd0; idle_end = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            start    = ($urandom % 4) == 0;
            stall    = ($urandom % 3) == 0;
            redirect = ($urandom % 8) == 0;
            if ($urandom % 2 == 0) redirect_pc = targets[$urandom % 6];
            else                   redirect_pc = 64'(($urandom % 20) * 4);
            // model one clock edge
            if (!m_started) begin
                if (start) m_started = 1;
            end else if (m_fault) begin
                m_val = 0;
            end else if (m_halt) begin
                if (!stall) m_val = 0;
            end else if (redirect) begin
                m_pc = redirect_pc; m_val = 0;
            end else if (m_val && stall) begin
                m_val = m_val;
            end else if (m_pc % 4 == 0 && m_pc <= 64'd76) begin
                m_ins = mem[m_pc / 4]; m_ipc = m_pc; m_val = 1; m_cnt = m_cnt + 1;
                if (m_pc == 64'd76) m_halt = 1;
                m_pc = m_pc + 4;
            end else begin
                m_val = 0; m_fault = 1;
            end
            step();
            n_tests++; if (if_valid !== m_val || Inst_Address !== m_pc) begin n_fail++; $display("FAIL rnd_ctl cyc %0d: valid %b addr %0h expected %b %0h", cyc, if_valid, Inst_Address, m_val, m_pc); end
            n_tests++; if (if_pc !== m_ipc || if_instruction !== m_ins) begin n_fail++; $display("FAIL rnd_data cyc %0d: pc %0h inst %h expected %0h %h", cyc, if_pc, if_instruction, m_ipc, m_ins); end
            n_tests++; if (fetch_count !== m_cnt || halted !== m_halt || fault !== m_fault) begin n_fail++; $display("FAIL rnd_status cyc %0d: cnt %0d halted %b fault %b expected %0d %b %b", cyc, fetch_count, halted, fault, m_cnt, m_halt, m_fault); end
            if (m_halt || m_fault) idle_end++;
            if (idle_end > 4) begin
                apply_reset();
                m_started = 0; m_halt = 0; m_fault = 0; m_val = 0;
                m_pc = 64'd0; m_ipc = 64'd0; m_ins = 32'h00000013; m_cnt = 32'd0; idle_end = 0;
            end
        end
        start = 1'b0; stall = 1'b0; redirect = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 20; i++) mem[i] = 32'h00000093 | (32'(i) << 20);
        mem[0]  = 32'h00800593;
        mem[1]  = 32'h04b68463;
        mem[3]  = 32'h01400ab3;
        mem[16] = 32'h008a0a13;
        mem[19] = 32'h00000013;
        apply_reset();
        test_reset();
        test_fetch_stall_redirect();
        test_straight_line();
        test_redirect_targets();
        test_reset_midrun();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
